// File: rtl/axis_result_packer.sv
// Packs 128-bit PPU result rows into a 64-bit AXI-Stream, two beats per row, low half first.
// Latency: a row accepted into an empty row FIFO appears as the low-half beat on the next cycle.
// Backpressure: axis_out_tready stalls beats with tdata/tlast held; o_row_ready drops when the FIFO is full or the tile's rows are all in.
module axis_result_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int M_W        = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [M_W-1:0] i_m_dim,
    input  logic           i_start,
    input  logic [127:0]   i_row_data,
    input  logic           i_row_valid,
    output logic           o_row_ready,
    output logic [63:0]    axis_out_tdata,
    output logic           axis_out_tvalid,
    input  logic           axis_out_tready,
    output logic           axis_out_tlast,
    output logic           o_busy,
    output logic           o_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [M_W-1:0] ROW_ONE  = 1;
    localparam logic [M_W:0]   BEAT_ONE = 1;

    state_t         state_q;
    state_t         state_d;
    logic [M_W-1:0] m_dim_q;
    logic [M_W-1:0] rows_in_q;
    logic [M_W:0]   beat_cnt_q;
    logic [M_W:0]   last_beat;
    logic           half_q;
    logic           zero_done_q;

    logic           start_acc;
    logic           start_zero;
    logic           row_push;
    logic           beat_hs;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [127:0]   head_dat;

    // A start is only honoured from IDLE; a zero-row tile just produces a done pulse.
    assign start_acc  = (state_q == IDLE) && i_start && (i_m_dim != '0);
    assign start_zero = (state_q == IDLE) && i_start && (i_m_dim == '0);

    // Final beat index, one bit wider than m_dim so 2*m_dim-1 cannot wrap.
    assign last_beat = {m_dim_q, 1'b0} - BEAT_ONE;

    // No push while full even if the head pops in the same cycle.
    assign o_row_ready     = (state_q == STREAM) && !fifo_full && (rows_in_q < m_dim_q);
    assign row_push        = i_row_valid && o_row_ready;
    assign axis_out_tvalid = (state_q == STREAM) && !fifo_empty;
    assign beat_hs         = axis_out_tvalid && axis_out_tready;
    assign fifo_pop        = beat_hs && half_q;
    assign axis_out_tlast  = axis_out_tvalid && (beat_cnt_q == last_beat);
    assign axis_out_tdata  = axis_out_tvalid ? (half_q ? head_dat[127:64] : head_dat[63:0]) : 64'd0;
    assign o_busy          = (state_q == STREAM);
    assign o_done          = (state_q == DONE) || zero_done_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the tile ends once its tlast beat has been taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_acc) state_d = STREAM;
            STREAM:  if (beat_hs && axis_out_tlast) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Tile bookkeeping: dimension latch, row/beat counters and the half-select bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dim_q     <= '0;
            rows_in_q   <= '0;
            beat_cnt_q  <= '0;
            half_q      <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= start_zero;
            if (start_acc) begin
                m_dim_q    <= i_m_dim;
                rows_in_q  <= '0;
                beat_cnt_q <= '0;
                half_q     <= 1'b0;
            end else begin
                if (row_push) begin
                    rows_in_q <= rows_in_q + ROW_ONE;
                end
                if (beat_hs) begin
                    half_q     <= ~half_q;
                    beat_cnt_q <= beat_cnt_q + BEAT_ONE;
                end
            end
        end
    end

    axis_result_packer_fifo #(
        .DW    (128),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_acc),
        .push_vld (row_push),
        .push_dat (i_row_data),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (head_dat)
    );

endmodule

// Generic synchronous FIFO with a combinational head read and a synchronous clear.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: caller must not push when full nor pop when empty.
module axis_result_packer_fifo #(
    parameter int DW    = 128,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [DW-1:0] mem [DEPTH];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_dat = mem[rd_ptr_q[AW-1:0]];

    // Pointer update; clear discards any stale contents at tile start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_vld) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)      rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Row storage is left unreset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: doc/axis_result_packer.md
AXIS_RESULT_PACKER -- requirements
Module: axis_result_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning row-FIFO depth in 128-bit rows, power of two, at least 2.
REQ-002 SHALL have parameter M_W, default 16, meaning width of the row-count configuration.
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_m_dim  input  M_W  rows per output tile, sampled on the i_start cycle.
REQ-006 SHALL have port i_start  input  1  single-cycle pulse that arms one tile transfer.
REQ-007 SHALL have port i_row_data  input  128  one PPU result row, 16 int8 lanes, lane 0 in bits [7:0].
REQ-008 SHALL have port i_row_valid  input  1  row-data qualifier from the PPU.
REQ-009 SHALL have port o_row_ready  output  1  row accepted when high with i_row_valid.
REQ-010 SHALL have port axis_out_tdata  output  64  stream beat to the DMA.
REQ-011 SHALL have port axis_out_tvalid  output  1  beat qualifier.
REQ-012 SHALL have port axis_out_tready  input  1  DMA back-pressure.
REQ-013 SHALL have port axis_out_tlast  output  1  final beat of the tile.
REQ-014 SHALL have port o_busy  output  1  high while in STREAM.
REQ-015 SHALL have port o_done  output  1  one-cycle pulse on tile completion.

Function
REQ-016 SHALL implement FSM states IDLE, STREAM, DONE.
- IDLE -> STREAM on i_start with i_m_dim != 0.
- STREAM -> DONE in the cycle after the tlast beat handshakes.
- DONE -> IDLE unconditionally after one cycle.
REQ-017 SHALL, on i_start with i_m_dim == 0, pulse o_done in the next cycle and remain in IDLE.
REQ-018 SHALL ignore i_start while in STREAM or DONE.
REQ-019 SHALL, on an accepted i_start, latch m_dim and clear rows_in, beat_cnt, the FIFO pointers and the half-select bit.
REQ-020 SHALL drive o_row_ready = (state == STREAM) && !fifo_full && (rows_in < m_dim).
- No push is allowed while full, even when a pop occurs in the same cycle.
REQ-021 SHALL push a row into the FIFO and increment rows_in on each i_row_valid && o_row_ready cycle.
REQ-022 SHALL, for the FIFO, use read/write pointers one bit wider than log2(FIFO_DEPTH).
- Full is defined as the MSBs differing with the low bits equal.
- Empty is defined as the pointers being equal.
- Pointers wrap modulo 2*FIFO_DEPTH.
REQ-023 SHALL drive axis_out_tvalid = (state == STREAM) && !fifo_empty.
REQ-024 SHALL drive axis_out_tdata from the FIFO head row.
- Bits [63:0] are driven when half == 0.
- Bits [127:64] are driven when half == 1.
REQ-025 SHALL, on each axis_out_tvalid && axis_out_tready handshake:
- toggle half;
- increment beat_cnt;
- pop the FIFO head when half == 1.
REQ-026 SHALL drive axis_out_tlast = axis_out_tvalid && (beat_cnt == 2*m_dim - 1).
REQ-027 SHALL hold tdata, tvalid and tlast stable while tvalid is high and tready is low.
REQ-028 SHALL present the low half of a row on axis_out_tvalid in the cycle after that row is accepted into an empty FIFO (latency 1).
REQ-029 SHALL sustain one beat per cycle with tready held high, i.e. one row per 2 cycles.
REQ-030 SHALL deassert axis_out_tvalid in DONE and IDLE.
REQ-031 SHALL compute 2*m_dim - 1 in M_W+1 bits so that no overflow occurs at m_dim = 2^M_W - 1.

Reset
REQ-032 SHALL, while rst_n is low, force:
- state to IDLE;
- all counters, pointers and half to 0;
- o_row_ready, axis_out_tvalid, axis_out_tlast, o_busy and o_done to 0;
- axis_out_tdata to 0.
REQ-033 SHALL, when reset is asserted mid-tile, abort the tile without asserting o_done, discard FIFO contents, and accept a new i_start after release.
REQ-034 SHALL not reset FIFO storage RAM contents.

Verification
REQ-035 SHALL cover basic transfer: m_dim=32, 32 rows each with lane i = row+i, tready=1.
- Expect 64 beats, the low half first for each row.
- Expect tlast only on beat 63.
- Expect o_done one cycle after beat 63.
REQ-036 SHALL cover back-pressure: m_dim=8, tready random 50%, PPU rows back-to-back.
- Expect o_row_ready to drop after 4 queued rows.
- Expect data stable while stalled.
- Expect no lost or duplicated beats.
REQ-037 SHALL cover row limit: m_dim=3 with 5 rows offered.
- Expect exactly 3 rows accepted and o_row_ready 0 after the third.
- Expect 6 beats, tlast on beat 5.
REQ-038 SHALL cover zero dimension: i_start with m_dim=0.
- Expect o_done one cycle later.
- Expect no tvalid and o_busy to stay 0.
REQ-039 SHALL cover restart while busy: i_start pulsed mid-tile with m_dim=4.
- Expect it to be ignored.
- Expect the original tile to complete with its original length.
REQ-040 SHALL cover reset mid-tile: rst_n low after beat 10 of a 64-beat tile.
- Expect all outputs 0 immediately and no o_done.
- Expect a following m_dim=2 tile to emit exactly 4 beats correctly.
